// File: rtl/tybec_pkg.sv
// rtl/tybec_pkg.sv - shared op encodings, limits and truncated-arithmetic helper for TyBEC map nodes
//
// Purpose: common definitions imported by the map-node pipeline and its stage.
// Ports: none (package).
//   OP_ADD/OP_SUB/OP_MUL/OP_MAC : operation selector encodings
//   LAT_MAX                     : deepest legal pipeline
//   STREAMW_MAX                 : widest stream the helper function supports
//   tybec_op_result()           : operation result truncated to a given width

package tybec_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_MAC = 3;

  localparam int LAT_MAX     = 16;
  localparam int STREAMW_MAX = 64;

  // Operands arrive zero-extended to STREAMW_MAX. Low-order bits of sums,
  // differences and products are identical for signed and unsigned
  // interpretation, so plain unsigned arithmetic followed by a width mask
  // yields the two's complement wrap-around result.
  function automatic logic [STREAMW_MAX-1:0] tybec_op_result(
    input int                     op,
    input int                     width,
    input logic [STREAMW_MAX-1:0] a,
    input logic [STREAMW_MAX-1:0] b,
    input logic [STREAMW_MAX-1:0] c
  );
    logic [STREAMW_MAX-1:0] mask;
    logic [STREAMW_MAX-1:0] r;
    if (width >= STREAMW_MAX) mask = '1;
    else                      mask = (STREAMW_MAX'(1) << width) - STREAMW_MAX'(1);
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      // in3 is added to the already-truncated product
      OP_MAC:  r = ((a * b) & mask) + c;
      default: r = '0;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/tybec_pipe_stage.sv
// rtl/tybec_pipe_stage.sv - one elastic register stage of the map-node pipeline
//
// Purpose: holds one data word and its valid bit; loads from upstream whenever
// it is empty or the downstream stage is itself advancing.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : upstream data
//   in_valid  : upstream valid
//   adv_next  : downstream stage advances (oready for the last stage)
//   adv       : this stage advances this cycle (ready seen by upstream)
//   data      : registered data
//   valid     : registered valid

module tybec_pipe_stage #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         adv_next,
  output logic         adv,
  output logic [W-1:0] data,
  output logic         valid
);

  // An empty stage can always take a word, which is what lets bubbles collapse.
  assign adv = ~valid | adv_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (adv) begin
      data  <= in_data;
      valid <= in_valid;
    end
  end

endmodule

// File: rtl/tybec_map_node_pipe.sv
// rtl/tybec_map_node_pipe.sv - elastic leaf map node: NIN-stream join, fixed-point op, LAT-stage pipeline
//
// Purpose: joins NIN input streams, applies OP (add/sub/mul/mac, truncated to
// STREAMW bits) and passes the result through LAT elastic stages to out1.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ivalid   : per-stream valid, bit k is stream k+1
//   in_data  : flattened inputs, stream k+1 at [k*STREAMW +: STREAMW]
//   iready   : shared ready for all input streams
//   ovalid   : result valid
//   out1     : result data
//   oready   : downstream ready
//   n_out    : results delivered, wraps modulo 2^32

module tybec_map_node_pipe
  import tybec_pkg::*;
#(
  parameter int STREAMW = 34,
  parameter int NIN     = 2,
  parameter int OP      = 0,
  parameter int LAT     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NIN-1:0]         ivalid,
  input  logic [NIN*STREAMW-1:0] in_data,
  output logic                   iready,
  output logic                   ovalid,
  output logic [STREAMW-1:0]     out1,
  input  logic                   oready,
  output logic [31:0]            n_out
);

  if (NIN != 2 && NIN != 3) begin : g_bad_nin
    $error("tybec_map_node_pipe: NIN must be 2 or 3");
  end
  if (OP < OP_ADD || OP > OP_MAC) begin : g_bad_op
    $error("tybec_map_node_pipe: OP must be 0..3");
  end
  if (OP == OP_MAC && NIN != 3) begin : g_bad_mac
    $error("tybec_map_node_pipe: OP_MAC needs NIN = 3");
  end
  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("tybec_map_node_pipe: LAT must be 1..16");
  end
  if (STREAMW < 1 || STREAMW > STREAMW_MAX) begin : g_bad_w
    $error("tybec_map_node_pipe: STREAMW must be 1..64");
  end

  // Join and datapath
  logic                   accept;
  logic [STREAMW_MAX-1:0] opa;
  logic [STREAMW_MAX-1:0] opb;
  logic [STREAMW_MAX-1:0] opc;
  logic [STREAMW_MAX-1:0] res_full;
  logic [STREAMW-1:0]     res;

  assign opa = STREAMW_MAX'(in_data[0 +: STREAMW]);
  assign opb = STREAMW_MAX'(in_data[STREAMW +: STREAMW]);

  if (NIN == 3) begin : g_in3
    assign opc = STREAMW_MAX'(in_data[2*STREAMW +: STREAMW]);
  end else begin : g_no_in3
    assign opc = '0;
  end

  assign res_full = tybec_op_result(OP, STREAMW, opa, opb, opc);
  assign res      = res_full[STREAMW-1:0];

  // The helper already masked these bits to zero.
  if (STREAMW < STREAMW_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = |res_full[STREAMW_MAX-1:STREAMW];
  end

  // Elastic pipeline: the ready chain runs from the tail back to the head,
  // the data/valid chain from the head to the tail.
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    logic [STREAMW-1:0] d_in;
    logic [STREAMW-1:0] d_q;
    logic               v_in;
    logic               v_q;
    logic               adv_next;
    logic               adv;

    if (s == 0) begin : g_head
      assign d_in = res;
      assign v_in = accept;
    end else begin : g_body
      assign d_in = g_stage[s-1].d_q;
      assign v_in = g_stage[s-1].v_q;
    end

    if (s == LAT - 1) begin : g_tail
      assign adv_next = oready;
    end else begin : g_mid
      assign adv_next = g_stage[s+1].adv;
    end

    tybec_pipe_stage #(.W(STREAMW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_data  (d_in),
      .in_valid (v_in),
      .adv_next (adv_next),
      .adv      (adv),
      .data     (d_q),
      .valid    (v_q)
    );
  end

  assign iready = g_stage[0].adv & ~rst;
  assign accept = (&ivalid) & iready;

  // Masking with rst keeps a stale tail word from handshaking during reset.
  assign ovalid = g_stage[LAT-1].v_q & ~rst;
  assign out1   = g_stage[LAT-1].d_q;

  always_ff @(posedge clk) begin
    if (rst)                   n_out <= '0;
    else if (ovalid && oready) n_out <= n_out + 32'd1;
  end

endmodule

// File: tb/tb_tybec_map_node_pipe.sv
// tb/tb_tybec_map_node_pipe.sv - self-checking bench for tybec_map_node_pipe

module tb_tybec_map_node_pipe;

  localparam int W = 34;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2:0]     ivalid = '0;
  logic [3*W-1:0] in_data = '0;
  logic           oready = 1'b0;

  logic [4:0]     iready_v;
  logic [4:0]     ovalid_v;
  logic [W-1:0]   out_v [5];
  logic [31:0]    nout_v [5];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // 0: add LAT4   1: sub LAT4   2: mul LAT4   3: mac LAT4 NIN3   4: add LAT7
  tybec_map_node_pipe #(.STREAMW(W), .NIN(2), .OP(0), .LAT(4)) d_add (
    .clk(clk), .rst(rst), .ivalid(ivalid[1:0]), .in_data(in_data[2*W-1:0]),
    .iready(iready_v[0]), .ovalid(ovalid_v[0]), .out1(out_v[0]), .oready(oready), .n_out(nout_v[0]));
  tybec_map_node_pipe #(.STREAMW(W), .NIN(2), .OP(1), .LAT(4)) d_sub (
    .clk(clk), .rst(rst), .ivalid(ivalid[1:0]), .in_data(in_data[2*W-1:0]),
    .iready(iready_v[1]), .ovalid(ovalid_v[1]), .out1(out_v[1]), .oready(oready), .n_out(nout_v[1]));
  tybec_map_node_pipe #(.STREAMW(W), .NIN(2), .OP(2), .LAT(4)) d_mul (
    .clk(clk), .rst(rst), .ivalid(ivalid[1:0]), .in_data(in_data[2*W-1:0]),
    .iready(iready_v[2]), .ovalid(ovalid_v[2]), .out1(out_v[2]), .oready(oready), .n_out(nout_v[2]));
  tybec_map_node_pipe #(.STREAMW(W), .NIN(3), .OP(3), .LAT(4)) d_mac (
    .clk(clk), .rst(rst), .ivalid(ivalid), .in_data(in_data),
    .iready(iready_v[3]), .ovalid(ovalid_v[3]), .out1(out_v[3]), .oready(oready), .n_out(nout_v[3]));
  tybec_map_node_pipe #(.STREAMW(W), .NIN(2), .OP(0), .LAT(7)) d_rnd (
    .clk(clk), .rst(rst), .ivalid(ivalid[1:0]), .in_data(in_data[2*W-1:0]),
    .iready(iready_v[4]), .ovalid(ovalid_v[4]), .out1(out_v[4]), .oready(oready), .n_out(nout_v[4]));

  // Reference model: FIFO of accepted results. A result can leave no earlier
  // than LAT cycles after its accept and no earlier than one cycle after the
  // previous result left; the node is full when LAT results are inside.
  typedef struct {
    logic [W-1:0] val;
    int           acc;
  } item_t;

  item_t mq[$];
  int    cyc = 0;
  int    last_leave = -1000;

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    mq.delete();
    last_leave = -1000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ivalid = '0; oready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one cycle at the falling edge, advances the model across the
  // following rising edge and returns what the model expects to see now.
  task automatic step(input int lat, input logic [2:0] iv, input logic [3*W-1:0] d,
                      input logic ord, input logic [W-1:0] newval, input logic [2:0] need,
                      output logic e_ird, output logic e_ov, output logic [W-1:0] e_out,
                      output logic acc);
    @(negedge clk);
    ivalid = iv; in_data = d; oready = ord;
    #1;
    e_ird = ord || (mq.size() < lat);
    e_ov  = (mq.size() > 0) && (cyc >= imax(mq[0].acc + lat, last_leave + 1));
    e_out = e_ov ? mq[0].val : '0;
    acc   = e_ird && ((iv & need) == need);
    if (e_ov && ord) begin
      void'(mq.pop_front());
      last_leave = cyc;
    end
    if (acc) mq.push_back('{newval, cyc});
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ivalid = '1; oready = 1'b1; in_data = '1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (iready_v[k] !== 1'b0 || ovalid_v[k] !== 1'b0 || out_v[k] !== '0 || nout_v[k] !== 32'd0)
        $display("FAIL reset dut%0d: iready=%b ovalid=%b out1=%h n_out=%0d, required 0/0/0/0",
                 k, iready_v[k], ovalid_v[k], out_v[k], nout_v[k]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0; ivalid = '0; oready = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    logic e_ird, e_ov, acc;
    logic [W-1:0] e_out;
    int sent, first_acc, first_ov, c;
    sent = 0; first_acc = -1; first_ov = -1;
    do_reset();
    for (int k = 0; k < 130; k++) begin
      c = cyc;
      step(4, (sent < 100) ? 3'b011 : 3'b000, {W'(0), W'(2 * sent), W'(sent)}, 1'b1,
           W'(3 * sent), 3'b011, e_ird, e_ov, e_out, acc);
      n_checks++;
      if (ovalid_v[0] !== e_ov) $display("FAIL stream_ovalid k=%0d got=%b exp=%b", k, ovalid_v[0], e_ov);
      else n_pass++;
      if (e_ov) begin
        n_checks++;
        if (out_v[0] !== e_out) $display("FAIL stream_out1 k=%0d got=%0d exp=%0d", k, out_v[0], e_out);
        else n_pass++;
      end
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (ovalid_v[0] === 1'b1 && first_ov < 0) first_ov = c;
    end
    n_checks++;
    if (first_ov - first_acc !== 4)
      $display("FAIL stream_latency got=%0d exp=4", first_ov - first_acc);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (nout_v[0] !== 32'd100) $display("FAIL stream_n_out got=%0d exp=100", nout_v[0]);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic e_ird, e_ov, acc;
    logic [W-1:0] e_out, a, b;
    int dut_acc;
    dut_acc = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      a = rnd_w(); b = rnd_w();
      step(4, 3'b011, {W'(0), b, a}, 1'b0, a - b, 3'b011, e_ird, e_ov, e_out, acc);
      n_checks++;
      if (iready_v[1] !== e_ird) $display("FAIL bp_iready k=%0d got=%b exp=%b", k, iready_v[1], e_ird);
      else n_pass++;
      if (iready_v[1] === 1'b1) dut_acc++;
    end
    n_checks++;
    if (dut_acc !== 4) $display("FAIL bp_fill_count got=%0d exp=4", dut_acc);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      step(4, 3'b000, '0, 1'b1, '0, 3'b011, e_ird, e_ov, e_out, acc);
      if (k == 0) begin
        n_checks++;
        if (iready_v[1] !== 1'b1) $display("FAIL bp_iready_rise got=%b exp=1", iready_v[1]);
        else n_pass++;
      end
      n_checks++;
      if (ovalid_v[1] !== e_ov) $display("FAIL bp_ovalid k=%0d got=%b exp=%b", k, ovalid_v[1], e_ov);
      else n_pass++;
      if (e_ov) begin
        n_checks++;
        if (out_v[1] !== e_out) $display("FAIL bp_out1 k=%0d got=%h exp=%h", k, out_v[1], e_out);
        else n_pass++;
      end
    end
  endtask

  task automatic test_partial_join();
    logic e_ird, e_ov, acc;
    logic [W-1:0] e_out, a, b;
    do_reset();
    for (int k = 0; k < 19; k++) begin
      a = rnd_w(); b = rnd_w();
      step(4, (k < 5) ? 3'b001 : ((k < 11) ? 3'b011 : 3'b000), {W'(0), b, a}, 1'b1,
           a + b, 3'b011, e_ird, e_ov, e_out, acc);
      n_checks++;
      if (ovalid_v[0] !== e_ov) $display("FAIL join_ovalid k=%0d got=%b exp=%b", k, ovalid_v[0], e_ov);
      else n_pass++;
      if (e_ov) begin
        n_checks++;
        if (out_v[0] !== e_out) $display("FAIL join_out1 k=%0d got=%h exp=%h", k, out_v[0], e_out);
        else n_pass++;
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (nout_v[0] !== 32'd6) $display("FAIL join_n_out got=%0d exp=6", nout_v[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic e_ird, e_ov, acc;
    logic [W-1:0] e_out, a, b, c, expv;
    logic [2*W-1:0] p;
    for (int u = 2; u <= 3; u++) begin
      do_reset();
      for (int k = 0; k < 12; k++) begin
        if (k == 0 && u == 2) begin
          a = W'(64'h2_0000_0000); b = W'(2); c = '0; expv = '0;
        end else if (k == 0) begin
          a = W'(-3); b = W'(5); c = W'(7); expv = W'(-8);
        end else begin
          a = rnd_w(); b = rnd_w(); c = rnd_w();
          p = {W'(0), a} * {W'(0), b};
          expv = (u == 2) ? p[W-1:0] : p[W-1:0] + c;
        end
        step(4, (k < 4) ? ((u == 2) ? 3'b011 : 3'b111) : 3'b000, {c, b, a}, 1'b1, expv,
             (u == 2) ? 3'b011 : 3'b111, e_ird, e_ov, e_out, acc);
        n_checks++;
        if (ovalid_v[u] !== e_ov) $display("FAIL wrap_ovalid dut%0d k=%0d got=%b exp=%b", u, k, ovalid_v[u], e_ov);
        else n_pass++;
        if (e_ov) begin
          n_checks++;
          if (out_v[u] !== e_out) $display("FAIL wrap_out1 dut%0d k=%0d got=%h exp=%h", u, k, out_v[u], e_out);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_random_stall();
    logic e_ird, e_ov, acc, ord, prev_hold;
    logic [2:0] iv;
    logic [W-1:0] e_out, a, b, prev_out;
    int delivered;
    delivered = 0; prev_hold = 1'b0; prev_out = '0;
    do_reset();
    for (int k = 0; k < 440; k++) begin
      a = rnd_w(); b = rnd_w();
      iv = (k < 400) ? {1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)} : 3'b000;
      ord = (k < 400) ? 1'($urandom_range(0, 9) < 6) : 1'b1;
      step(7, iv, {W'(0), b, a}, ord, a + b, 3'b011, e_ird, e_ov, e_out, acc);
      n_checks++;
      if (iready_v[4] !== e_ird || ovalid_v[4] !== e_ov)
        $display("FAIL rnd_ctrl k=%0d iready=%b ovalid=%b exp %b %b", k, iready_v[4], ovalid_v[4], e_ird, e_ov);
      else n_pass++;
      if (e_ov) begin
        n_checks++;
        if (out_v[4] !== e_out) $display("FAIL rnd_out1 k=%0d got=%h exp=%h", k, out_v[4], e_out);
        else n_pass++;
        if (ord) delivered++;
      end
      if (prev_hold) begin
        n_checks++;
        if (ovalid_v[4] !== 1'b1 || out_v[4] !== prev_out)
          $display("FAIL rnd_stable k=%0d ovalid=%b out1=%h held=%h", k, ovalid_v[4], out_v[4], prev_out);
        else n_pass++;
      end
      prev_hold = ovalid_v[4] && !ord;
      prev_out  = out_v[4];
    end
    @(negedge clk); #1;
    n_checks++;
    if (nout_v[4] !== 32'(delivered) || mq.size() != 0)
      $display("FAIL rnd_n_out got=%0d exp=%0d pending=%0d", nout_v[4], delivered, mq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic e_ird, e_ov, acc;
    logic [W-1:0] e_out, a, b;
    int c0, cf;
    cf = -1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = rnd_w(); b = rnd_w();
      step(4, 3'b011, {W'(0), b, a}, 1'b0, a + b, 3'b011, e_ird, e_ov, e_out, acc);
    end
    @(negedge clk);
    rst = 1'b1; ivalid = 3'b011; oready = 1'b1;
    #1;
    n_checks++;
    if (iready_v[0] !== 1'b0) $display("FAIL rstmid_iready got=%b exp=0", iready_v[0]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; ivalid = '0;
    #1;
    n_checks++;
    if (ovalid_v[0] !== 1'b0 || out_v[0] !== '0 || nout_v[0] !== 32'd0)
      $display("FAIL rstmid_clear ovalid=%b out1=%h n_out=%0d exp 0/0/0", ovalid_v[0], out_v[0], nout_v[0]);
    else n_pass++;
    model_reset();
    a = rnd_w(); b = rnd_w();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      step(4, (k == 0) ? 3'b011 : 3'b000, {W'(0), b, a}, 1'b1, a + b, 3'b011, e_ird, e_ov, e_out, acc);
      n_checks++;
      if (ovalid_v[0] !== e_ov) $display("FAIL rstmid_ovalid k=%0d got=%b exp=%b", k, ovalid_v[0], e_ov);
      else n_pass++;
      if (e_ov) begin
        n_checks++;
        if (out_v[0] !== e_out) $display("FAIL rstmid_out1 got=%h exp=%h", out_v[0], e_out);
        else n_pass++;
      end
      if (ovalid_v[0] === 1'b1 && cf < 0) cf = cyc - 1;
    end
    n_checks++;
    if (cf - c0 !== 4) $display("FAIL rstmid_latency got=%0d exp=4", cf - c0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_partial_join();
    test_wrap();
    test_random_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
